// File: rtl/crc_pkg.sv
// Shared types, polynomial constants and helpers for the framed CRC stream engine.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } crc_state_t;

    localparam logic [15:0] CRC16_ANSI_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

    // Reverses the low 'width' bits of v; bits at and above 'width' come back as zero.
    function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int unsigned width);
        logic [63:0] res;
        res = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width) begin
                res[i] = v[width - 1 - i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/crc_parallel_step.sv
// Combinational fold of DATA_W input bits into a CRC_W remainder, bit 0 of the beat first.
module crc_parallel_step
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_ANSI_POLY),
    parameter int               DATA_W = 8
) (
    input  logic [CRC_W-1:0]  rem_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  rem_o
);

    logic [CRC_W-1:0] rem;

    // Each iteration is one LFSR shift; the shifted-out MSB is dropped by the fixed width.
    always_comb begin
        rem = rem_i;
        for (int i = 0; i < DATA_W; i++) begin
            if (data_i[i] ^ rem[CRC_W-1]) begin
                rem = (rem << 1) ^ POLY;
            end else begin
                rem = rem << 1;
            end
        end
        rem_o = rem;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Word-parallel framed CRC engine: folds one beat per cycle and holds one result per frame
// behind a valid/ready handshake.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(CRC16_ANSI_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT = '0,
    parameter logic [CRC_W-1:0] XOR_OUT  = '0,
    parameter bit               REFL_OUT = 1'b0,
    parameter int               DATA_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              sof_i,
    input  logic              eof_i,
    output logic              ready_o,
    output logic [CRC_W-1:0]  crc_o,
    output logic              crc_valid_o,
    input  logic              crc_ready_i
);

    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] rem_q, rem_d;
    logic [CRC_W-1:0] crcOut_q, crcOut_d;
    logic             crcValid_q, crcValid_d;
    logic             ready_q, ready_d;

    logic [CRC_W-1:0] stepIn;
    logic [CRC_W-1:0] remStep;
    logic [CRC_W-1:0] crcFinal;
    logic             accept;

    // A start-of-frame beat always restarts from CRC_INIT, even when a frame is open.
    assign stepIn = sof_i ? CRC_INIT : rem_q;
    assign accept = valid_i && ready_q;

    crc_parallel_step #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .rem_i  (stepIn),
        .data_i (data_i),
        .rem_o  (remStep)
    );

    always_comb begin
        if (REFL_OUT) begin
            crcFinal = CRC_W'(bit_reverse(64'(remStep), CRC_W)) ^ XOR_OUT;
        end else begin
            crcFinal = remStep ^ XOR_OUT;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        crcOut_d   = crcOut_q;
        crcValid_d = crcValid_q;

        unique case (state_q)
            IDLE: begin
                if (accept && sof_i) begin
                    rem_d   = remStep;
                    state_d = eof_i ? HOLD : ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    rem_d   = remStep;
                    state_d = eof_i ? HOLD : ACTIVE;
                end
            end
            HOLD: begin
                if (crc_ready_i && crcValid_q) begin
                    state_d    = IDLE;
                    crcValid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != HOLD && state_d == HOLD) begin
            crcOut_d   = crcFinal;
            crcValid_d = 1'b1;
        end

        // Registered ready keeps the upstream handshake free of combinational paths.
        ready_d = (state_d != HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rem_q      <= CRC_INIT;
            crcOut_q   <= '0;
            crcValid_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            crcOut_q   <= crcOut_d;
            crcValid_q <= crcValid_d;
            ready_q    <= ready_d;
        end
    end

    assign ready_o     = ready_q;
    assign crc_o       = crcOut_q;
    assign crc_valid_o = crcValid_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: five parameter variants share one control stream and are
// checked against a bit-serial CRC-16/ANSI reference.
module tb_crc_stream_engine;

    // Variants: 0 default (W=8), 1 XOR_OUT=FFFF, 2 REFL_OUT=1, 3 DATA_W=1, 4 DATA_W=32
    localparam int NDUT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        sof;
    logic        eof;
    logic        crcReady;
    logic [31:0] dataBus;

    logic [15:0] crcOut   [NDUT];
    logic        crcValid [NDUT];
    logic        readyOut [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc_stream_engine u_def (
        .clk_i(clk), .rst_i(rst), .data_i(dataBus[7:0]), .valid_i(valid), .sof_i(sof), .eof_i(eof),
        .ready_o(readyOut[0]), .crc_o(crcOut[0]), .crc_valid_o(crcValid[0]), .crc_ready_i(crcReady)
    );

    crc_stream_engine #(.XOR_OUT(16'hFFFF)) u_xor (
        .clk_i(clk), .rst_i(rst), .data_i(dataBus[7:0]), .valid_i(valid), .sof_i(sof), .eof_i(eof),
        .ready_o(readyOut[1]), .crc_o(crcOut[1]), .crc_valid_o(crcValid[1]), .crc_ready_i(crcReady)
    );

    crc_stream_engine #(.REFL_OUT(1'b1)) u_refl (
        .clk_i(clk), .rst_i(rst), .data_i(dataBus[7:0]), .valid_i(valid), .sof_i(sof), .eof_i(eof),
        .ready_o(readyOut[2]), .crc_o(crcOut[2]), .crc_valid_o(crcValid[2]), .crc_ready_i(crcReady)
    );

    crc_stream_engine #(.DATA_W(1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .data_i(dataBus[0:0]), .valid_i(valid), .sof_i(sof), .eof_i(eof),
        .ready_o(readyOut[3]), .crc_o(crcOut[3]), .crc_valid_o(crcValid[3]), .crc_ready_i(crcReady)
    );

    crc_stream_engine #(.DATA_W(32)) u_w32 (
        .clk_i(clk), .rst_i(rst), .data_i(dataBus), .valid_i(valid), .sof_i(sof), .eof_i(eof),
        .ready_o(readyOut[4]), .crc_o(crcOut[4]), .crc_valid_o(crcValid[4]), .crc_ready_i(crcReady)
    );

    function automatic int widthOf(input int k);
        case (k)
            3:       return 1;
            4:       return 32;
            default: return 8;
        endcase
    endfunction

    // Serial CRC-16/ANSI: shift in n message bits LSB-first as polynomial long division.
    function automatic logic [15:0] serialCrc(input logic [15:0] r, input logic [31:0] d, input int n);
        logic [15:0] acc;
        logic        top;
        acc = r;
        for (int i = 0; i < n; i++) begin
            top = acc[15] ^ d[i];
            acc = {acc[14:0], 1'b0};
            if (top) acc = acc ^ 16'h8005;
        end
        return acc;
    endfunction

    function automatic logic [15:0] finalize(input logic [15:0] r, input int k);
        logic [15:0] o;
        o = r;
        if (k == 2) begin
            for (int i = 0; i < 16; i++) o[i] = r[15 - i];
        end
        if (k == 1) o = o ^ 16'hFFFF;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic s, input logic e);
        valid   = 1'b1;
        dataBus = d;
        sof     = s;
        eof     = e;
        step();
        valid = 1'b0;
        sof   = 1'b0;
        eof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; sof = 1'b0; eof = 1'b0; crcReady = 1'b0; dataBus = '0;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (readyOut[k] !== 1'b1 || crcValid[k] !== 1'b0 || crcOut[k] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_state dut%0d: ready=%b valid=%b crc=%h, expected ready=1 valid=0 crc=0000",
                         k, readyOut[k], crcValid[k], crcOut[k]);
            end
        end
    endtask

    task automatic test_single_beat();
        logic [15:0] expv [4];
        expv[0] = 16'h8303; expv[1] = 16'h7CFC; expv[2] = 16'hC0C1; expv[3] = 16'h8005;
        crcReady = 1'b0;
        sendBeat(32'h0000_0001, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (crcValid[k] !== 1'b1 || crcOut[k] !== expv[k] || readyOut[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_beat dut%0d: valid=%b crc=%h ready=%b, expected valid=1 crc=%h ready=0",
                         k, crcValid[k], crcOut[k], readyOut[k], expv[k]);
            end
        end
        crcReady = 1'b1;
        step();
        crcReady = 1'b0;
        checks++;
        if (crcValid[0] !== 1'b0 || readyOut[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_beat_release: valid=%b ready=%b, expected valid=0 ready=1",
                     crcValid[0], readyOut[0]);
        end
    endtask

    task automatic test_zero_frame();
        sendBeat(32'h0, 1'b1, 1'b0);
        sendBeat(32'h0, 1'b0, 1'b0);
        sendBeat(32'h0, 1'b0, 1'b0);
        sendBeat(32'h0, 1'b0, 1'b1);
        checks++;
        if (crcValid[0] !== 1'b1 || crcOut[0] !== 16'h0000 || crcOut[1] !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL zero_frame: valid=%b crc=%h crcXor=%h, expected valid=1 crc=0000 crcXor=FFFF",
                     crcValid[0], crcOut[0], crcOut[1]);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (readyOut[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_frame_hold_ready cycle%0d: ready=%b, expected 0", c, readyOut[0]);
            end
        end
        crcReady = 1'b1;
        step();
        crcReady = 1'b0;
        checks++;
        if (readyOut[0] !== 1'b1 || crcValid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_frame_release: ready=%b valid=%b, expected ready=1 valid=0",
                     readyOut[0], crcValid[0]);
        end
    endtask

    task automatic test_backpressure();
        sendBeat(32'h0000_0001, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            valid   = 1'b1;
            sof     = 1'b1;
            eof     = 1'b1;
            dataBus = $urandom;
            step();
            checks++;
            if (crcValid[0] !== 1'b1 || crcOut[0] !== 16'h8303 || readyOut[0] !== 1'b0 ||
                crcOut[2] !== 16'hC0C1) begin
                errors++;
                $display("[TB] FAIL backpressure cycle%0d: valid=%b crc=%h refl=%h ready=%b, expected 1 8303 C0C1 0",
                         c, crcValid[0], crcOut[0], crcOut[2], readyOut[0]);
            end
        end
        valid = 1'b0; sof = 1'b0; eof = 1'b0;
        crcReady = 1'b1;
        step();
        crcReady = 1'b0;
        checks++;
        if (readyOut[0] !== 1'b1 || crcValid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_release: ready=%b valid=%b, expected ready=1 valid=0",
                     readyOut[0], crcValid[0]);
        end
    endtask

    task automatic test_restart();
        sendBeat(32'h0000_00AA, 1'b1, 1'b0);
        sendBeat(32'h0000_0001, 1'b1, 1'b1);
        checks++;
        if (crcValid[0] !== 1'b1 || crcOut[0] !== 16'h8303) begin
            errors++;
            $display("[TB] FAIL restart: valid=%b crc=%h, expected valid=1 crc=8303", crcValid[0], crcOut[0]);
        end
        crcReady = 1'b1;
        step();
        crcReady = 1'b0;
        sendBeat(32'h0000_0001, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (crcValid[0] !== 1'b0 || readyOut[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL no_sof_dropped cycle%0d: valid=%b ready=%b, expected valid=0 ready=1",
                         c, crcValid[0], readyOut[0]);
            end
            step();
        end
    endtask

    task automatic test_reset_in_hold();
        sendBeat(32'h0000_0001, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (crcValid[0] !== 1'b0 || crcOut[0] !== 16'h0000 || readyOut[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_hold: valid=%b crc=%h ready=%b, expected valid=0 crc=0000 ready=1",
                     crcValid[0], crcOut[0], readyOut[0]);
        end
        sendBeat(32'h0000_00AA, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sendBeat(32'h0000_0001, 1'b0, 1'b1);
        checks++;
        if (crcValid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_frame: valid=%b, expected 0 (open frame discarded)", crcValid[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] mRem [NDUT];
        logic [15:0] mCrc [NDUT];
        bit          mHold, mActive, mValid, first, accept;
        int          beatsLeft, frames, cycles;
        logic [31:0] curData;

        mHold = 0; mActive = 0; mValid = 0; first = 0;
        beatsLeft = 0; frames = 0; cycles = 0; curData = '0;
        for (int k = 0; k < NDUT; k++) begin
            mRem[k] = '0;
            mCrc[k] = '0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;

        while (frames < 200 && cycles < 20000) begin
            cycles++;
            if (!mHold) begin
                if (beatsLeft == 0) begin
                    beatsLeft = $urandom_range(1, 16);
                    first     = 1;
                    curData   = $urandom;
                end
                valid   = ($urandom_range(0, 3) != 0);
                sof     = first;
                eof     = (beatsLeft == 1);
                dataBus = curData;
            end else begin
                valid   = $urandom_range(0, 1) != 0;
                sof     = $urandom_range(0, 1) != 0;
                eof     = $urandom_range(0, 1) != 0;
                dataBus = $urandom;
            end
            crcReady = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 99) == 0);

            accept = valid && !mHold;
            if (rst) begin
                mHold = 0; mActive = 0; mValid = 0; beatsLeft = 0;
            end else if (mHold) begin
                if (crcReady) begin
                    mHold  = 0;
                    mValid = 0;
                    frames++;
                end
            end else if (accept) begin
                if (sof || mActive) begin
                    for (int k = 0; k < NDUT; k++) begin
                        mRem[k] = serialCrc(sof ? 16'h0000 : mRem[k], dataBus, widthOf(k));
                    end
                    if (eof) begin
                        mHold = 1; mValid = 1; mActive = 0;
                        for (int k = 0; k < NDUT; k++) mCrc[k] = finalize(mRem[k], k);
                    end else begin
                        mActive = 1;
                    end
                end
                beatsLeft--;
                first   = 0;
                curData = $urandom;
            end

            step();
            rst = 1'b0;
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (readyOut[k] !== !mHold || crcValid[k] !== mValid ||
                    (mValid && crcOut[k] !== mCrc[k])) begin
                    errors++;
                    $display("[TB] FAIL random dut%0d cycle%0d: ready=%b valid=%b crc=%h, expected ready=%b valid=%b crc=%h",
                             k, cycles, readyOut[k], crcValid[k], crcOut[k], !mHold, mValid, mCrc[k]);
                end
            end
        end
        valid = 1'b0; sof = 1'b0; eof = 1'b0; crcReady = 1'b0;
        checks++;
        if (frames < 200) begin
            errors++;
            $display("[TB] FAIL random_budget: completed %0d frames, expected 200 within cycle budget", frames);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_zero_frame();
        test_backpressure();
        test_restart();
        test_reset_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
